// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: state encoding and default widths.
package mem_stage_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned RW_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUSY   = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// Writeback bundle register: data/reg/flags loaded on load_i; valid pulses for one cycle per load.
module mem_wb_reg #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic [RW-1:0] reg_i,
    input  logic          en_i,
    input  logic          halt_i,
    input  logic          err_i,
    output logic [DW-1:0] data_o,
    output logic [RW-1:0] reg_o,
    output logic          en_o,
    output logic          halt_o,
    output logic          err_o,
    output logic          valid_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o  <= '0;
            reg_o   <= '0;
            en_o    <= 1'b0;
            halt_o  <= 1'b0;
            err_o   <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= load_i;
            if (load_i) begin
                data_o <= data_i;
                reg_o  <= reg_i;
                en_o   <= en_i;
                halt_o <= halt_i;
                err_o  <= err_i;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: retires ALU ops in one cycle, runs loads/stores through a req/done handshake.
// Optional MEM_ALIGN_CHECK_EN: odd-address memory ops retire immediately with err=1 and no request.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_data,
    input  logic [DW-1:0] st_data,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          reg_write,
    input  logic          halt,
    input  logic [RW-1:0] wr_reg,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_done,
    output logic          out_valid,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_reg,
    output logic          wb_en,
    output logic          halt_out,
    output logic          err
);

    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic          rd_q, rd_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [RW-1:0] reg_q, reg_d;
    logic          regw_q, regw_d;

    logic          accept_c;
    logic          misalign_c;
    logic          load_c;
    logic [DW-1:0] bd_data_c;
    logic [RW-1:0] bd_reg_c;
    logic          bd_en_c, bd_halt_c, bd_err_c;

    assign accept_c = in_valid & ready_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_c = (mem_read | mem_write) & alu_data[0];
`else
    assign misalign_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            reg_q   <= '0;
            regw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            reg_q   <= reg_d;
            regw_q  <= regw_d;
        end
    end

    // Next state, request latching and writeback bundle selection.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        reg_d     = reg_q;
        regw_d    = regw_q;
        load_c    = 1'b0;
        bd_data_c = alu_data;
        bd_reg_c  = wr_reg;
        bd_en_c   = reg_write;
        bd_halt_c = 1'b0;
        bd_err_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (halt) begin
                        load_c    = 1'b1;
                        bd_halt_c = 1'b1;
                        state_d   = ST_HALTED;
                    end else if (misalign_c) begin
                        load_c   = 1'b1;
                        bd_en_c  = 1'b0;
                        bd_err_c = 1'b1;
                    end else if (mem_read | mem_write) begin
                        state_d = ST_BUSY;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        rd_d    = mem_read;
                        addr_d  = alu_data;
                        wdata_d = st_data;
                        reg_d   = wr_reg;
                        regw_d  = reg_write;
                    end else begin
                        load_c = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (dmem_done) begin
                    load_c    = 1'b1;
                    req_d     = 1'b0;
                    state_d   = ST_IDLE;
                    bd_data_c = we_q ? addr_q : dmem_rdata;
                    bd_reg_c  = reg_q;
                    // A read+write op is performed as a store and never writes back.
                    bd_en_c   = regw_q & ~(rd_q & we_q);
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    assign in_ready   = ready_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    mem_wb_reg #(
        .DW (DW),
        .RW (RW)
    ) u_wb_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_c),
        .data_i  (bd_data_c),
        .reg_i   (bd_reg_c),
        .en_i    (bd_en_c),
        .halt_i  (bd_halt_c),
        .err_i   (bd_err_c),
        .data_o  (wb_data),
        .reg_o   (wb_reg),
        .en_o    (wb_en),
        .halt_o  (halt_out),
        .err_o   (err),
        .valid_o (out_valid)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table for ALU ops plus sequences for memory, reset and halt.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] alu_data, st_data;
    logic        mem_read, mem_write, reg_write, halt;
    logic [2:0]  wr_reg;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_done;
    logic        out_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_reg;
    logic        wb_en, halt_out, err;

    int checks   = 0;
    int failures = 0;
    int retired  = 0;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  r;
        logic        en;
        logic        hlt;
        logic        er;
    } exp_t;

    typedef struct {
        logic [15:0] alu;
        logic [2:0]  rg;
        logic        rw;
        logic [15:0] exp_d;
        logic [2:0]  exp_r;
        logic        exp_en;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];

    mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_data   (alu_data),
        .st_data    (st_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .halt       (halt),
        .wr_reg     (wr_reg),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_done  (dmem_done),
        .out_valid  (out_valid),
        .wb_data    (wb_data),
        .wb_reg     (wb_reg),
        .wb_en      (wb_en),
        .halt_out   (halt_out),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every retire must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_retire actual=out_valid=1 expected=out_valid=0 t=%0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_data", 32'(wb_data), 32'(e.d));
                chk("wb_reg", 32'(wb_reg), 32'(e.r));
                chk("wb_en", 32'(wb_en), 32'(e.en));
                chk("halt_out", 32'(halt_out), 32'(e.hlt));
                chk("err", 32'(err), 32'(e.er));
                retired++;
            end
        end
    end

    task automatic idle_inputs();
        in_valid = 0; alu_data = '0; st_data = '0; mem_read = 0; mem_write = 0;
        reg_write = 0; halt = 0; wr_reg = '0;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] s, input logic rd,
                         input logic wr, input logic rw, input logic [2:0] rg, input logic h);
        in_valid = 1; alu_data = a; st_data = s; mem_read = rd; mem_write = wr;
        reg_write = rw; wr_reg = rg; halt = h;
    endtask

    task automatic push(input logic [15:0] d, input logic [2:0] r, input logic en,
                        input logic h, input logic e);
        exp_t x;
        x.d = d; x.r = r; x.en = en; x.hlt = h; x.er = e;
        exp_q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 3'd3, 1'b1, 16'h1234, 3'd3, 1'b1};
        vecs[1] = '{16'hFFFF, 3'd7, 1'b0, 16'hFFFF, 3'd7, 1'b0};
        vecs[2] = '{16'h0000, 3'd0, 1'b1, 16'h0000, 3'd0, 1'b1};
        vecs[3] = '{16'h8001, 3'd5, 1'b1, 16'h8001, 3'd5, 1'b1};
        vecs[4] = '{16'h00FF, 3'd1, 1'b0, 16'h00FF, 3'd1, 1'b0};

        rst_n = 0; dmem_done = 0; dmem_rdata = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        chk("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wb", 32'({wb_data, wb_reg, wb_en, halt_out, err}), 32'd0);

        // Release reset and present the first op in the same cycle; back-to-back ALU ops.
        step();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].alu, 16'h0, 0, 0, vecs[i].rw, vecs[i].rg, 0);
            push(vecs[i].exp_d, vecs[i].exp_r, vecs[i].exp_en, 0, 0);
            chk("tbl_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        idle_inputs();
        @(negedge clk);
        chk("tbl_last_valid", 32'(out_valid), 32'd1);
        #1;
        chk("tbl_retired", 32'(retired), 32'd5);
        step();
        @(negedge clk);
        chk("idle_no_valid", 32'(out_valid), 32'd0);
        chk("idle_hold_data", 32'(wb_data), 32'h00FF);

        // dmem_done with no outstanding request must be ignored.
        step();
        dmem_done = 1; dmem_rdata = 16'hDEAD;
        repeat (2) begin
            @(negedge clk);
            chk("stray_done_req", 32'(dmem_req), 32'd0);
            step();
        end
        dmem_done = 0;

        // Load with three request cycles.
        issue(16'h0040, 16'h0, 1, 0, 1, 3'd2, 0);
        push(16'hBEEF, 3'd2, 1, 0, 0);
        step();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin dmem_done = 1; dmem_rdata = 16'hBEEF; end
            @(negedge clk);
            chk("ld_req", 32'(dmem_req), 32'd1);
            chk("ld_ready", 32'(in_ready), 32'd0);
            chk("ld_addr_we", 32'({dmem_addr, dmem_we}), 32'({16'h0040, 1'b0}));
            chk("ld_no_valid", 32'(out_valid), 32'd0);
            step();
        end
        dmem_done = 0;
        @(negedge clk);
        chk("ld_req_drop", 32'(dmem_req), 32'd0);
        chk("ld_ready_back", 32'(in_ready), 32'd1);
        wait_drain("ld_drain", 4);

        // Store flagged as read+write, done in the first request cycle.
        step();
        issue(16'h0010, 16'hA5A5, 1, 1, 1, 3'd4, 0);
        push(16'h0010, 3'd4, 0, 0, 0);
        step();
        idle_inputs();
        dmem_done = 1; dmem_rdata = 16'h5555;
        @(negedge clk);
        chk("st_req", 32'(dmem_req), 32'd1);
        chk("st_we", 32'(dmem_we), 32'd1);
        chk("st_wdata", 32'(dmem_wdata), 32'hA5A5);
        chk("st_addr", 32'(dmem_addr), 32'h0010);
        step();
        dmem_done = 0;
        wait_drain("st_drain", 4);

        // Odd-address load.
        step();
        issue(16'h0011, 16'h0, 1, 0, 1, 3'd6, 0);
`ifdef MEM_ALIGN_CHECK_EN
        push(16'h0011, 3'd6, 0, 0, 1);
        step();
        idle_inputs();
        @(negedge clk);
        chk("odd_no_req", 32'(dmem_req), 32'd0);
        chk("odd_valid", 32'(out_valid), 32'd1);
`else
        push(16'h7777, 3'd6, 1, 0, 0);
        step();
        idle_inputs();
        dmem_done = 1; dmem_rdata = 16'h7777;
        @(negedge clk);
        chk("odd_req", 32'(dmem_req), 32'd1);
        chk("odd_addr", 32'(dmem_addr), 32'h0011);
        step();
        dmem_done = 0;
`endif
        wait_drain("odd_drain", 4);

        // Reset in the middle of a load abandons it.
        step();
        issue(16'h0080, 16'h0, 1, 0, 1, 3'd1, 0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("rb_req_before", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 0;
        dmem_done = 1; dmem_rdata = 16'h1111;
        #1;
        chk("rb_req_now", 32'(dmem_req), 32'd0);
        chk("rb_ready_now", 32'(in_ready), 32'd1);
        chk("rb_addr_now", 32'(dmem_addr), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1;
        repeat (5) begin
            @(negedge clk);
            chk("rb_no_valid", 32'(out_valid), 32'd0);
            chk("rb_no_req", 32'(dmem_req), 32'd0);
        end
        dmem_done = 0;

        // Halt retires once, then the stage refuses everything.
        step();
        issue(16'h0099, 16'h0, 0, 0, 1, 3'd1, 1);
        push(16'h0099, 3'd1, 1, 1, 0);
        step();
        issue(16'h0042, 16'h0, 1, 0, 1, 3'd2, 0);
        @(negedge clk);
        chk("halt_valid", 32'(out_valid), 32'd1);
        repeat (22) begin
            step();
            @(negedge clk);
            chk("halt_ready", 32'(in_ready), 32'd0);
            chk("halt_req", 32'(dmem_req), 32'd0);
        end
        idle_inputs();
        chk("halt_hold", 32'(halt_out), 32'd1);
        wait_drain("halt_drain", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
